router_pkt_tx: RTL and testbench
================================

// Module: router_pkt_tx
// PURPOSE
//  Packet transmitter driving the router input port (pkt_valid, data_in, busy, err).
//  Buffers one payload from a host byte stream, then emits header, payload and parity.
//  Parity is a running XOR. Honours the router busy stall.
//  After the parity byte, samples router err and reports pass/fail to the host.
// PARAMETERS
//  MAX_LEN   63  largest payload length accepted, in bytes (1..63; the header field is 6 bits)
//  ERR_WAIT  3   cycles after the parity byte is accepted during which router err is sampled
// PORTS
//  clock        in   1  system clock, rising edge
//  resetn       in   1  asynchronous active-low reset
//  tx_start     in   1  request to send; qualified only while tx_ready=1
//  tx_addr      in   2  destination port (0..2)
//  tx_len       in   6  payload length in bytes
//  pl_data      in   8  payload byte from host
//  pl_valid     in   1  pl_data valid
//  pl_ready     out  1  block accepts pl_data this cycle
//  tx_ready     out  1  idle; tx_start is accepted
//  pkt_valid    out  1  to router pkt_valid
//  tx_data      out  8  to router data_in
//  busy         in   1  from router; when 1, hold tx_data and pkt_valid
//  err          in   1  from router parity error
//  tx_done      out  1  one-cycle pulse at end of CHECK
//  tx_err       out  1  valid with tx_done; 1 = router flagged err
// BEHAVIOUR
//  Reset values: state IDLE, tx_ready=1, and pl_ready, pkt_valid, tx_data, tx_done, tx_err all 0.
//    All counters and parity are 0. Buffer contents are don't-care.
//  All outputs are registered or decoded from registered state. No input-to-output combinational path.
//  IDLE: tx_ready=1.
//    On tx_start with tx_addr!=3 and 1<=tx_len<=MAX_LEN: latch addr and len.
//      Set par={tx_len,tx_addr}, wcnt=0, go to LOAD.
//    On tx_start with an illegal addr or len: ignore it; no transfer and no tx_done.
//  LOAD: pl_ready=1.
//    Each cycle with pl_valid=1: buf[wcnt]<=pl_data, par^=pl_data, wcnt++.
//    When the byte with wcnt==len-1 is written, go to HEADER.
//  HEADER: pkt_valid=1, tx_data={len,addr}.
//    At an edge with busy=0 the byte is accepted; set rcnt=0 and go to PAYLOAD.
//  PAYLOAD: pkt_valid=1, tx_data=buf[rcnt].
//    At an edge with busy=0: rcnt++. After the byte at rcnt==len-1 is accepted, go to PARITY.
//  PARITY: pkt_valid=0, tx_data=par.
//    At an edge with busy=0, go to CHECK and clear ecnt.
//  CHECK: pkt_valid=0, tx_data=0. Run ERR_WAIT cycles, OR-ing err into a sticky flag.
//    In the last cycle: tx_done=1, tx_err=flag, go to IDLE.
//  busy=1 in HEADER, PAYLOAD or PARITY: hold state, tx_data and pkt_valid unchanged, with no limit.
//    busy is ignored in all other states.
//  Timing: each emitted byte is held at least one cycle. With busy=0 throughout, bytes go out on consecutive cycles.
//  Minimum packet time = len (LOAD, no gaps) + 1 + len + 1 + ERR_WAIT cycles.
//  tx_start while not IDLE is ignored. tx_ready returns 1 in the cycle after the tx_done pulse.
//  Reset asserted mid-operation: immediately go to IDLE with all outputs at reset values. The partial packet is abandoned.
// TESTING
//  1 addr=1, len=3, payload 11,22,33, busy=0
//    -> tx_data 0D,11,22,33 with pkt_valid=1, then 0D with pkt_valid=0; tx_done with tx_err=0.
//  2 Same packet, busy=1 for 4 cycles during the 2nd payload byte
//    -> tx_data=22 held 5 cycles; the sequence is otherwise identical.
//  3 tx_start with addr=3, or with len=0 -> tx_ready stays 1, pkt_valid never asserts, no tx_done.
//  4 addr=2, len=63, payload 00..3E -> header FE, 63 payload bytes in order, parity = FE ^ XOR(00..3E).
//  5 err=1 pulse one cycle after the parity byte is accepted -> tx_done with tx_err=1.
//  6 resetn low during PAYLOAD -> pkt_valid=0 asynchronously, tx_ready=1 after release.
//    A following len=1 packet is sent correctly.

Source files
------------

// File: rtl/router_pkt_tx_if.sv
// Host and router side signals of the packet transmitter.
// The slave modport is the transmitter; the master modport is the host/router model.
interface router_pkt_tx_if;
    logic       tx_start;
    logic [1:0] tx_addr;
    logic [5:0] tx_len;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       tx_ready;
    logic       pkt_valid;
    logic [7:0] tx_data;
    logic       busy;
    logic       err;
    logic       tx_done;
    logic       tx_err;

    modport slave (
        input  tx_start, tx_addr, tx_len, pl_data, pl_valid, busy, err,
        output pl_ready, tx_ready, pkt_valid, tx_data, tx_done, tx_err
    );

    modport master (
        output tx_start, tx_addr, tx_len, pl_data, pl_valid, busy, err,
        input  pl_ready, tx_ready, pkt_valid, tx_data, tx_done, tx_err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a host payload, then sends header, payload
// and running-XOR parity to the router, and reports the router err verdict.
module router_pkt_tx #(
    parameter int MAX_LEN  = 63,
    parameter int ERR_WAIT = 3
) (
    input  logic            clock,
    input  logic            resetn,
    router_pkt_tx_if.slave  bus
);
    localparam int EW = (ERR_WAIT < 2) ? 1 : $clog2(ERR_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_CHECK
    } state_t;

    state_t        r_state;
    logic [1:0]    r_addr;
    logic [5:0]    r_len;
    logic [5:0]    r_wcnt;
    logic [5:0]    r_rcnt;
    logic [EW-1:0] r_ecnt;
    logic [7:0]    r_par;
    logic          r_flag;
    logic          r_pl_ready;
    logic          r_tx_ready;
    logic          r_pkt_valid;
    logic [7:0]    r_tx_data;
    logic          r_tx_done;
    logic          r_tx_err;
    logic [7:0]    r_buf [64];

    logic          w_start_ok;
    logic          w_wr;

    assign w_start_ok = bus.tx_start && (bus.tx_addr != 2'd3) && (bus.tx_len != 6'd0)
                        && (int'(bus.tx_len) <= MAX_LEN);
    assign w_wr       = (r_state == S_LOAD) && bus.pl_valid;

    assign bus.pl_ready  = r_pl_ready;
    assign bus.tx_ready  = r_tx_ready;
    assign bus.pkt_valid = r_pkt_valid;
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_done   = r_tx_done;
    assign bus.tx_err    = r_tx_err;

    // Payload storage carries no reset; contents are only read after being written.
    always_ff @(posedge clock) begin
        if (w_wr)
            r_buf[r_wcnt] <= bus.pl_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_ecnt      <= '0;
            r_par       <= '0;
            r_flag      <= 1'b0;
            r_pl_ready  <= 1'b0;
            r_tx_ready  <= 1'b1;
            r_pkt_valid <= 1'b0;
            r_tx_data   <= '0;
            r_tx_done   <= 1'b0;
            r_tx_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_addr     <= bus.tx_addr;
                        r_len      <= bus.tx_len;
                        r_par      <= {bus.tx_len, bus.tx_addr};
                        r_wcnt     <= '0;
                        r_tx_ready <= 1'b0;
                        r_pl_ready <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.pl_valid) begin
                        r_par  <= r_par ^ bus.pl_data;
                        r_wcnt <= r_wcnt + 6'd1;
                        if (r_wcnt == r_len - 6'd1) begin
                            r_pl_ready  <= 1'b0;
                            r_pkt_valid <= 1'b1;
                            r_tx_data   <= {r_len, r_addr};
                            r_state     <= S_HEADER;
                        end
                    end
                end
                S_HEADER: begin
                    if (!bus.busy) begin
                        r_rcnt    <= '0;
                        r_tx_data <= r_buf[0];
                        r_state   <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (!bus.busy) begin
                        if (r_rcnt == r_len - 6'd1) begin
                            r_pkt_valid <= 1'b0;
                            r_tx_data   <= r_par;
                            r_state     <= S_PARITY;
                        end else begin
                            r_rcnt    <= r_rcnt + 6'd1;
                            r_tx_data <= r_buf[r_rcnt + 6'd1];
                        end
                    end
                end
                S_PARITY: begin
                    if (!bus.busy) begin
                        r_tx_data <= '0;
                        r_ecnt    <= '0;
                        r_flag    <= 1'b0;
                        // A one-cycle window leaves no room to sample err before done.
                        r_tx_done <= (ERR_WAIT == 1);
                        r_tx_err  <= 1'b0;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_tx_done) begin
                        r_tx_done  <= 1'b0;
                        r_tx_err   <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        // tx_done is registered, so it is raised one edge ahead of the last cycle.
                        r_flag <= r_flag | bus.err;
                        r_ecnt <= r_ecnt + 1'b1;
                        if (int'(r_ecnt) == ERR_WAIT - 2) begin
                            r_tx_done <= 1'b1;
                            r_tx_err  <= r_flag | bus.err;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: table of packets plus hand-written
// sequences for illegal starts and mid-packet reset.
module tb_router_pkt_tx;
    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   n_chk  = 0;
    int   n_err  = 0;

    router_pkt_tx_if bus();

    router_pkt_tx #(.MAX_LEN(63), .ERR_WAIT(3)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] addr;
        logic [5:0] len;
        logic [7:0] base;
        logic [7:0] step;
        int         stall_k;
        int         stall_n;
        bit         err_pulse;
        logic [7:0] hdr;
        logic [7:0] par;
        bit         exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pbyte(input vec_t v, input int i);
        logic [7:0] ib;
        ib = 8'(i);
        return v.base + v.step * ib;
    endfunction

    task automatic run_pkt(input vec_t v);
        logic [7:0] eb;
        logic       ev;
        int         n;
        @(negedge clock);
        bus.tx_start = 1'b1;
        bus.tx_addr  = v.addr;
        bus.tx_len   = v.len;
        @(negedge clock);
        bus.tx_start = 1'b0;
        chk("load_pl_ready", {31'd0, bus.pl_ready}, 32'd1);
        chk("load_tx_ready", {31'd0, bus.tx_ready}, 32'd0);
        for (int i = 0; i < int'(v.len); i++) begin
            bus.pl_data  = pbyte(v, i);
            bus.pl_valid = 1'b1;
            @(negedge clock);
        end
        bus.pl_valid = 1'b0;
        chk("hdr_pl_ready", {31'd0, bus.pl_ready}, 32'd0);
        for (int k = 0; k <= int'(v.len) + 1; k++) begin
            if (k == 0)               eb = v.hdr;
            else if (k <= int'(v.len)) eb = pbyte(v, k - 1);
            else                      eb = v.par;
            ev = (k <= int'(v.len));
            chk($sformatf("byte%0d", k), {24'd0, bus.tx_data}, {24'd0, eb});
            chk($sformatf("pkt_valid%0d", k), {31'd0, bus.pkt_valid}, {31'd0, ev});
            if (k == v.stall_k) begin
                bus.busy = 1'b1;
                repeat (v.stall_n) begin
                    @(negedge clock);
                    chk($sformatf("hold%0d", k), {23'd0, bus.pkt_valid, bus.tx_data}, {23'd0, ev, eb});
                end
                bus.busy = 1'b0;
            end
            @(negedge clock);
        end
        chk("check_tx_data", {24'd0, bus.tx_data}, 32'd0);
        chk("check_pkt_valid", {31'd0, bus.pkt_valid}, 32'd0);
        n = 0;
        while (!bus.tx_done && n < 20) begin
            bus.err = (n == 0) && v.err_pulse;
            @(negedge clock);
            bus.err = 1'b0;
            n++;
        end
        chk("done_latency", n, 32'd2);
        chk("tx_err", {31'd0, bus.tx_err}, {31'd0, v.exp_err});
        @(negedge clock);
        chk("done_pulse_end", {31'd0, bus.tx_done}, 32'd0);
        chk("ready_after_done", {31'd0, bus.tx_ready}, 32'd1);
    endtask

    task automatic bad_start(input logic [1:0] a, input logic [5:0] l);
        @(negedge clock);
        bus.tx_start = 1'b1;
        bus.tx_addr  = a;
        bus.tx_len   = l;
        @(negedge clock);
        bus.tx_start = 1'b0;
        repeat (8) begin
            chk("bad_ready", {29'd0, bus.tx_ready, bus.pkt_valid, bus.tx_done}, 32'b100);
            chk("bad_pl_ready", {31'd0, bus.pl_ready}, 32'd0);
            @(negedge clock);
        end
    endtask

    initial begin
        vecs[0] = '{2'd1, 6'd3,  8'h11, 8'h11, -1, 0, 1'b0, 8'h0D, 8'h0D, 1'b0};
        vecs[1] = '{2'd1, 6'd3,  8'h11, 8'h11,  2, 4, 1'b0, 8'h0D, 8'h0D, 1'b0};
        vecs[2] = '{2'd2, 6'd63, 8'h00, 8'h01, -1, 0, 1'b0, 8'hFE, 8'hC1, 1'b0};
        vecs[3] = '{2'd1, 6'd3,  8'h11, 8'h11, -1, 0, 1'b1, 8'h0D, 8'h0D, 1'b1};
        vecs[4] = '{2'd0, 6'd1,  8'h5A, 8'h00,  4, 3, 1'b0, 8'h04, 8'h5E, 1'b0};
        vecs[5] = '{2'd1, 6'd2,  8'h80, 8'h01,  0, 2, 1'b0, 8'h09, 8'h08, 1'b0};

        bus.tx_start = 1'b0; bus.tx_addr = '0; bus.tx_len = '0;
        bus.pl_data  = '0;   bus.pl_valid = 1'b0;
        bus.busy     = 1'b0; bus.err = 1'b0;

        repeat (3) @(negedge clock);
        chk("rst_outputs", {20'd0, bus.tx_ready, bus.pl_ready, bus.pkt_valid, bus.tx_done, bus.tx_err, 7'd0},
            {20'd0, 1'b1, 4'b0000, 7'd0});
        chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        chk("idle_ready", {31'd0, bus.tx_ready}, 32'd1);

        for (int t = 0; t < 6; t++)
            run_pkt(vecs[t]);

        bad_start(2'd3, 6'd3);
        bad_start(2'd1, 6'd0);

        // Reset while the first payload byte is on the bus.
        @(negedge clock);
        bus.tx_start = 1'b1; bus.tx_addr = 2'd1; bus.tx_len = 6'd4;
        @(negedge clock);
        bus.tx_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.pl_data = 8'hA0 + 8'(i); bus.pl_valid = 1'b1;
            @(negedge clock);
        end
        bus.pl_valid = 1'b0;
        @(negedge clock);
        chk("pre_rst_payload", {23'd0, bus.pkt_valid, bus.tx_data}, {23'd0, 1'b1, 8'hA0});
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_pkt_valid", {31'd0, bus.pkt_valid}, 32'd0);
        chk("async_rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", {31'd0, bus.tx_ready}, 32'd1);
        run_pkt(vecs[4]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
